// File: rtl/au_pkg.sv
// Shared arithmetic-unit definitions: prefix-network architecture codes and a
// behavioural leading-one reference for scoreboards.
package au_pkg;

    localparam int AU_ARCH_RIPPLE = 0;
    localparam int AU_ARCH_PREFIX = 1;
    localparam int AU_MAX_WIDTH   = 64;

    // One-hot of the most significant set bit among the low `width` bits of a.
    function automatic logic [AU_MAX_WIDTH-1:0] lzd_onehot(
        input logic [AU_MAX_WIDTH-1:0] a,
        input int                      width
    );
        logic [AU_MAX_WIDTH-1:0] result;
        logic                    found;
        result = '0;
        found  = 1'b0;
        for (int i = AU_MAX_WIDTH - 1; i >= 0; i--) begin
            if (!found && (i < width) && a[i]) begin
                result[i] = 1'b1;
                found     = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/au_prefix_or.sv
// MSB-first prefix OR: p[i] is the OR of a[WIDTH-1:i]. ARCH selects a ripple
// chain or a Sklansky log-depth tree; both compute the same function.
module au_prefix_or
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ARCH  = AU_ARCH_RIPPLE
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] p
);

    generate
        if (ARCH == AU_ARCH_PREFIX) begin : g_sklansky
            localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

            // Index 0 of r is the MSB of a, so a standard LSB-first tree applies.
            logic [WIDTH-1:0] r;
            logic [WIDTH-1:0] lvl [LEVELS+1];

            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
                assign r[gi]           = a[WIDTH-1-gi];
                assign p[WIDTH-1-gi]   = lvl[LEVELS][gi];
            end

            // Upper half of each 2^k block ORs in the last bit of its lower half;
            // indices past WIDTH simply do not exist, which prunes the tree.
            always_comb begin
                for (int k = 0; k <= LEVELS; k++) begin
                    lvl[k] = '0;
                end
                lvl[0] = r;
                for (int k = 1; k <= LEVELS; k++) begin
                    for (int j = 0; j < WIDTH; j++) begin
                        if (j[k-1]) begin
                            lvl[k][j] = lvl[k-1][j]
                                      | lvl[k-1][((j >> k) << k) + (1 << (k - 1)) - 1];
                        end else begin
                            lvl[k][j] = lvl[k-1][j];
                        end
                    end
                end
            end
        end else begin : g_ripple
            always_comb begin
                p            = '0;
                p[WIDTH-1]   = a[WIDTH-1];
                for (int i = WIDTH - 2; i >= 0; i--) begin
                    p[i] = p[i+1] | a[i];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/au_lead_zero_det.sv
// Registered leading-one detector: one-hot of the most significant '1' in a,
// plus a flag when a is all zeros. One pipeline stage.
module au_lead_zero_det
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ARCH  = AU_ARCH_RIPPLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] z,
    output logic             no_det
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] zc;
    logic             no_det_c;

    au_prefix_or #(
        .WIDTH (WIDTH),
        .ARCH  (ARCH)
    ) u_prefix_or (
        .a (a),
        .p (p)
    );

    // A bit is the leader when it is set and nothing above it is.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
            if (gi == WIDTH - 1) begin : g_msb
                assign zc[gi] = a[gi];
            end else begin : g_low
                assign zc[gi] = a[gi] & ~p[gi+1];
            end
        end
    endgenerate

    assign no_det_c = ~p[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z      <= '0;
            no_det <= 1'b1;
        end else begin
            z      <= zc;
            no_det <= no_det_c;
        end
    end

endmodule

// File: tb/tb_au_lead_zero_det.sv
// Directed and sweep checks of au_lead_zero_det across several WIDTH/ARCH
// instances driven from one shared input word.
module tb_au_lead_zero_det;

    localparam int N = 14;
    localparam int W_TAB [N] = '{8, 8, 16, 16, 1, 1, 5, 5, 13, 13, 32, 32, 64, 64};
    localparam int A_TAB [N] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a_in;
    logic [63:0] z_out  [N];
    logic        nd_out [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            localparam int W = W_TAB[gi];
            logic [W-1:0] z_loc;
            logic         nd_loc;
            au_lead_zero_det #(
                .WIDTH (W),
                .ARCH  (A_TAB[gi])
            ) u_dut (
                .clk    (clk),
                .rst_n  (rst_n),
                .a      (a_in[W-1:0]),
                .z      (z_loc),
                .no_det (nd_loc)
            );
            assign z_out[gi]  = 64'(z_loc);
            assign nd_out[gi] = nd_loc;
        end
    endgenerate

    // Independent model: walk down from the top bit of the word.
    function automatic logic [63:0] model_z(input logic [63:0] x, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (x[i]) return 64'd1 << i;
        end
        return 64'd0;
    endfunction

    function automatic logic [63:0] width_mask(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic check(input string tag, input int idx,
                         input logic [63:0] ez, input logic en);
        checks++;
        assert (z_out[idx] === ez && nd_out[idx] === en) else begin
            errors++;
            $error("FAIL %s inst=%0d W=%0d ARCH=%0d a=%h z=%h no_det=%b expected z=%h no_det=%b",
                   tag, idx, W_TAB[idx], A_TAB[idx], a_in, z_out[idx], nd_out[idx], ez, en);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] x);
        logic [63:0] xm;
        for (int i = 0; i < N; i++) begin
            xm = x & width_mask(W_TAB[i]);
            check(tag, i, model_z(xm, W_TAB[i]), (xm == 64'd0));
        end
    endtask

    // Directed check on both 8-bit instances with a hand-computed answer.
    task automatic check8(input string tag, input logic [7:0] ez, input logic en);
        check(tag, 0, 64'(ez), en);
        check(tag, 1, 64'(ez), en);
        $display("step %-12s a=%h z=%h no_det=%b", tag, a_in[7:0], z_out[0][7:0], nd_out[0]);
    endtask

    task automatic step(input logic [63:0] x);
        a_in = x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_in  = 64'hFF;
        repeat (2) @(posedge clk);
        #1;
        check8("rst_hold", 8'h00, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check8("rst_release", 8'h80, 1'b0);

        step(64'h00); check8("zero", 8'h00, 1'b1);
        step(64'hFF); check8("all_ones", 8'h80, 1'b0);
        step(64'h01); check8("lsb_only", 8'h01, 1'b0);
        step(64'h13); check8("trail_13", 8'h10, 1'b0);

        // Output must not follow a new input before the next edge.
        a_in = 64'h7F;
        #1;
        check8("latency_hold", 8'h10, 1'b0);
        @(posedge clk);
        #1;
        check8("trail_7f", 8'h40, 1'b0);

        // Reset asserted between edges clears outputs immediately.
        step(64'hFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check8("rst_async", 8'h00, 1'b1);
        a_in = 64'h13;
        @(posedge clk);
        #1;
        check8("rst_mid", 8'h00, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check8("rst_resume", 8'h10, 1'b0);

        // WIDTH = 1 instances.
        step(64'h1);
        check("w1_one", 4, 64'h1, 1'b0);
        check("w1_one", 5, 64'h1, 1'b0);
        $display("step w1_one a=1 z=%h no_det=%b", z_out[4], nd_out[4]);
        step(64'h0);
        check("w1_zero", 4, 64'h0, 1'b1);
        check("w1_zero", 5, 64'h0, 1'b1);
        $display("step w1_zero a=0 z=%h no_det=%b", z_out[4], nd_out[4]);

        // Wide instances: zeros and ones first.
        step(64'h0);
        check("w64_zero", 12, 64'h0, 1'b1);
        check("w64_zero", 13, 64'h0, 1'b1);
        check("w32_zero", 10, 64'h0, 1'b1);
        $display("step wide_zero a=0");
        step({64{1'b1}});
        check("w64_ones", 12, 64'h8000_0000_0000_0000, 1'b0);
        check("w64_ones", 13, 64'h8000_0000_0000_0000, 1'b0);
        check("w32_ones", 10, 64'h0000_0000_8000_0000, 1'b0);
        check("w32_ones", 11, 64'h0000_0000_8000_0000, 1'b0);
        check("w13_ones", 8,  64'h0000_0000_0000_1000, 1'b0);
        check("w5_ones",  7,  64'h0000_0000_0000_0010, 1'b0);
        check("w16_ones", 3,  64'h0000_0000_0000_8000, 1'b0);
        $display("step wide_ones a=%h z64=%h", a_in, z_out[12]);

        // Exhaustive over 16 bits covers 1/5/8/13/16-bit instances completely.
        $display("phase exhaustive16 start");
        for (int v = 0; v < 65536; v++) begin
            step(64'(v));
            check_all("exhaustive", 64'(v));
        end

        // Back-to-back random words; the shift spreads the leader position.
        $display("phase random start");
        for (int n = 0; n < 10000; n++) begin
            logic [63:0] x;
            x = {$urandom, $urandom} >> $urandom_range(0, 63);
            step(x);
            check_all("random", x);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
